// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Streaming multiply-accumulate back end. It takes the 8-bit products from the
//   4x4 combinational array multiplier as a valid/ready stream, sums them into
//   a dot product, and emits one registered result beat per vector. A vector
//   closes on in_last, or is force-closed once MAX_TERMS products have been
//   summed.
//
//   Optional build macro: SATURATE_EN
//     defined   : every add clamps at 2^ACC_W-1 (sticky for the vector)
//     undefined : adds wrap modulo 2^ACC_W
//   In both builds out_ovf reports that some add in the vector carried out.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   in_prod    : product from the multiplier (unsigned)
//   in_valid   : in_prod / in_last valid this cycle
//   in_last    : this product is the final term of the vector
//   in_ready   : block accepts a product this cycle (high only in ACCUM)
//   out_sum    : accumulated result
//   out_count  : number of terms in out_sum
//   out_forced : result closed by MAX_TERMS rather than by in_last
//   out_ovf    : accumulator carried out of ACC_W during this vector
//   out_valid  : result beat valid
//   out_ready  : consumer accepts the result
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_forced,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               forced_q, forced_d;
    logic               oovf_q, oovf_d;
    logic               vld_q, vld_d;

    logic               accept;
    logic [CNT_W-1:0]   cnt_inc;
    logic               close;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   add_res;

    // in_ready depends on state only, so no combinational path from in_valid.
    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid & in_ready;

    assign cnt_inc  = cnt_q + 1'b1;
    assign close    = in_last | (cnt_inc == MAX_CNT);

    // One extra bit catches the carry out of the accumulator width.
    assign sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    assign carry    = sum_ext[ACC_W];

`ifdef SATURATE_EN
    // Once clamped, acc stays at all-ones: any further nonzero add carries
    // again and a zero add leaves it unchanged.
    assign add_res  = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign add_res  = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        sum_d    = sum_q;
        count_d  = count_q;
        forced_d = forced_q;
        oovf_d   = oovf_q;
        vld_d    = vld_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (close) begin
                        sum_d    = add_res;
                        count_d  = cnt_inc;
                        forced_d = ~in_last;
                        oovf_d   = ovf_q | carry;
                        vld_d    = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        state_d  = HOLD;
                    end else begin
                        acc_d    = add_res;
                        cnt_d    = cnt_inc;
                        ovf_d    = ovf_q | carry;
                    end
                end
            end
            HOLD: begin
                // Result registers are left untouched here, so they stay
                // stable for as long as the consumer stalls.
                if (vld_q & out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sum_q    <= '0;
            count_q  <= '0;
            forced_q <= 1'b0;
            oovf_q   <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            forced_q <= forced_d;
            oovf_q   <= oovf_d;
            vld_q    <= vld_d;
        end
    end

    assign out_sum    = sum_q;
    assign out_count  = count_q;
    assign out_forced = forced_q;
    assign out_ovf    = oovf_q;
    assign out_valid  = vld_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int PROD_W    = 8;
    localparam int ACC_W     = 10;
    localparam int MAX_TERMS = 16;
    localparam int CNT_W     = 8;
    localparam int ACC_MAX   = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [PROD_W-1:0] in_prod;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_forced;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    product_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_sum(out_sum), .out_count(out_count), .out_forced(out_forced),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cnt;
        bit forced;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   bp_rand = 1'b0;
    bit   stop_mon = 1'b0;

    // software model state for the random phase
    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input int s, input int c, input bit f, input bit o);
        exp_t e;
        e.sum = s; e.cnt = c; e.forced = f; e.ovf = o;
        q.push_back(e);
    endtask

    task automatic model_accept(input int prod, input bit last);
        int  s;
        bit  c;
        int  r;
        int  c1;
        s  = m_acc + prod;
        c  = (s > ACC_MAX);
`ifdef SATURATE_EN
        r  = c ? ACC_MAX : s;
`else
        r  = c ? s - (ACC_MAX + 1) : s;
`endif
        c1 = m_cnt + 1;
        if (last || c1 == MAX_TERMS) begin
            push_exp(r, c1, !last, m_ovf | c);
            m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        end else begin
            m_acc = r; m_cnt = c1; m_ovf = m_ovf | c;
        end
    endtask

    // Present one beat starting just after a rising edge; returns just after
    // the edge that accepted it.
    task automatic send(input int prod, input bit last, input bit use_model);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_prod  = PROD_W'(prod);
        in_last  = last;
        for (int w = 0; w < 1000 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (use_model) model_accept(prod, last);
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int bound);
        int w = 0;
        while ((q.size() != 0 || out_valid) && w < bound) begin
            @(posedge clk); #1; w++;
        end
        if (w >= bound) chk("drain_timeout", q.size(), 0);
    endtask

    // Scoreboard monitor: a result is consumed at the edge after a negedge
    // where out_valid & out_ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!stop_mon && !rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_sum",    int'(out_sum),    e.sum);
                    chk("out_count",  int'(out_count),  e.cnt);
                    chk("out_forced", int'(out_forced), int'(e.forced));
                    chk("out_ovf",    int'(out_ovf),    int'(e.ovf));
                end
            end
        end
    end

    // Random consumer backpressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst = 1'b1; in_prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid",  int'(out_valid),  0);
        chk("rst_in_ready",   int'(in_ready),   1);
        chk("rst_out_sum",    int'(out_sum),    0);
        chk("rst_out_count",  int'(out_count),  0);
        chk("rst_out_forced", int'(out_forced), 0);
        chk("rst_out_ovf",    int'(out_ovf),    0);
        @(posedge clk); #1;

        // 4 x 225 with last, consumer stalled for 5 cycles
        push_exp(900, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(225, i == 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready",  int'(in_ready),  0);
            chk("hold_out_sum",   int'(out_sum),   900);
            chk("hold_out_count", int'(out_count), 4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;

        // 16 ones force a flush, then 4 more closing on last
        push_exp(16, 16, 1'b1, 1'b0);
        push_exp(4, 4, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send(1, i == 19, 1'b0);
        drain(100);

        // last coinciding with MAX_TERMS is not forced
        push_exp(16, 16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send(1, i == 15, 1'b0);
        // single-term vector
        push_exp(200, 1, 1'b0, 1'b0);
        send(200, 1'b1, 1'b0);
        // overflow: 5 x 225 = 1125 against a 10-bit accumulator
`ifdef SATURATE_EN
        push_exp(1023, 5, 1'b0, 1'b1);
`else
        push_exp(101, 5, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 5; i++) send(225, i == 4, 1'b0);
        drain(100);

        // reset mid-vector discards the partial sum
        for (int i = 0; i < 3; i++) send(9, 1'b0, 1'b0);
        rst = 1'b1; idle(1); rst = 1'b0;
        push_exp(7, 1, 1'b0, 1'b0);
        send(7, 1'b1, 1'b0);
        drain(100);

        // reset while a result is held drops it without a beat
        out_ready = 1'b0;
        send(5, 1'b1, 1'b0);
        idle(2);
        rst = 1'b1; idle(1); rst = 1'b0;
        @(negedge clk);
        chk("rst_hold_out_valid", int'(out_valid), 0);
        chk("rst_hold_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;

        // random vectors against the model with random backpressure
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        bp_rand = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                idle($urandom_range(0, 1));
                send($urandom_range(0, 225), b == len - 1, 1'b1);
            end
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;
        drain(200);
        stop_mon = 1'b1;
        chk("leftover_expected", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
